// File: rtl/io_tube_responder.sv
// Memory-mapped 8-digit seven-segment display peripheral: CPU-written digit word,
// enable and decimal-point masks, multiplexed with blank guard slots and frame-atomic commits.
module io_tube_responder #(
  parameter int unsigned SCAN_DIVIDER = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        iClock,
  input  logic        iResetN,
  input  logic        iDoTubeWrite,
  input  logic [3:0]  iAddrLow,
  input  logic [31:0] iWriteData,
  output logic [7:0]  oDigitSelect,
  output logic [7:0]  oSegments,
  output logic        oFrameDone
);

  localparam int unsigned CNT_MAX = (SCAN_DIVIDER > BLANK_CYCLES) ? SCAN_DIVIDER : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIVIDER - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_ENABLE = 4'h4;
  localparam logic [3:0] ADDR_DP     = 4'h8;

  typedef enum logic {BLANK, SHOW} tubeStateT;

  tubeStateT        state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [2:0]       idx, idxNext;
  logic             firstExit, firstExitNext;
  logic             commit;

  logic [31:0] pendData, showData, showDataNext;
  logic [7:0]  pendEnable, showEnable, showEnableNext;
  logic [7:0]  pendDp, showDp, showDpNext;

  logic [7:0]  digitSelectNext;
  logic [7:0]  segmentsNext;
  logic        frameDoneNext;
  logic [3:0]  nibble;

  // Active-low g..a pattern for one hex digit
  function automatic logic [6:0] hexToSeg(input logic [3:0] value);
    logic [6:0] seg;
    seg = 7'h7F;
    case (value)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // CPU-facing pending registers; only the display copies are ever scanned out
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      pendData   <= '0;
      pendEnable <= 8'hFF;
      pendDp     <= '0;
    end else if (iDoTubeWrite) begin
      case (iAddrLow)
        ADDR_DATA:   pendData   <= iWriteData;
        ADDR_ENABLE: pendEnable <= iWriteData[7:0];
        ADDR_DP:     pendDp     <= iWriteData[7:0];
        default:     ;
      endcase
    end
  end

  // Scan state, display copies and registered outputs
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      state        <= BLANK;
      cnt          <= '0;
      idx          <= '0;
      firstExit    <= 1'b1;
      showData     <= '0;
      showEnable   <= 8'hFF;
      showDp       <= '0;
      oDigitSelect <= 8'hFF;
      oSegments    <= 8'hFF;
      oFrameDone   <= 1'b0;
    end else begin
      state        <= stateNext;
      cnt          <= cntNext;
      idx          <= idxNext;
      firstExit    <= firstExitNext;
      showData     <= showDataNext;
      showEnable   <= showEnableNext;
      showDp       <= showDpNext;
      oDigitSelect <= digitSelectNext;
      oSegments    <= segmentsNext;
      oFrameDone   <= frameDoneNext;
    end
  end

  // Next state, and outputs computed for the state being entered
  always_comb begin
    stateNext       = state;
    cntNext         = cnt + CNT_W'(1);
    idxNext         = idx;
    firstExitNext   = firstExit;
    commit          = 1'b0;
    frameDoneNext   = 1'b0;
    digitSelectNext = 8'hFF;
    segmentsNext    = 8'hFF;

    if (state == BLANK) begin
      if (cnt == BLANK_LAST) begin
        stateNext = SHOW;
        cntNext   = '0;
        // The first exit after reset only starts digit 0; it does not end a frame
        if (firstExit) begin
          firstExitNext = 1'b0;
        end else if (idx == 3'd7) begin
          idxNext       = '0;
          commit        = 1'b1;
          frameDoneNext = 1'b1;
        end else begin
          idxNext = idx + 3'd1;
        end
      end
    end else begin
      if (cnt == SHOW_LAST) begin
        stateNext = BLANK;
        cntNext   = '0;
      end
    end

    showDataNext   = commit ? pendData   : showData;
    showEnableNext = commit ? pendEnable : showEnable;
    showDpNext     = commit ? pendDp     : showDp;

    nibble = showDataNext[{idxNext, 2'b00} +: 4];
    if (stateNext == SHOW && showEnableNext[idxNext]) begin
      digitSelectNext[idxNext] = 1'b0;
      segmentsNext = {~showDpNext[idxNext], hexToSeg(nibble)};
    end
  end

endmodule
